butterfly_stage_scheduler: RTL and testbench

BUTTERFLY_STAGE_SCHEDULER -- requirements
Module: butterfly_stage_scheduler

---
 rtl/butterfly_stage_scheduler.sv | 260 ++++++++++++++++++++++++++
 tb/tb_butterfly_stage_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_stage_scheduler.sv
// butterfly_stage_scheduler
// Sequences a multi-stage butterfly/FFT command through weight load, stage
// start, input streaming and pipeline drain for each stage. It pulses done
// when the last stage drains and err when a command is rejected.
//
// Optional build macro: SCHED_PERF_CNT_EN adds the perf_cycles output. That
// output counts busy cycles for the current or last command.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_vld/cmd_rdy   command handshake (cmd_rdy high only when idle)
//   cmd_length        transform length in points (power of two)
//   cmd_is_fft        1 = FFT mode, 0 = butterfly-matrix mode
//   cmd_num_stages    stages to run (1..MAX_STAGES)
//   cmd_wbeats        weight beats to load per stage
//   wgt_in_vld        weight beat strobe (counted only while loading)
//   in_vld/in_rdy     input data handshake (in_rdy high only while running)
//   length, is_fft    latched command fields
//   is_bypass_p2s     high on every stage but the last
//   butterfly_start   one-cycle pulse at the start of each stage
//   stage_idx         current stage index
//   busy, done, err   status; done/err are one-cycle pulses
//   perf_cycles       busy-cycle counter (SCHED_PERF_CNT_EN only)
module butterfly_stage_scheduler #(
  parameter int unsigned BU_PARALLELISM = 4,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter int unsigned MAX_STAGES     = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [15:0] cmd_length,
  input  logic        cmd_is_fft,
  input  logic [3:0]  cmd_num_stages,
  input  logic [11:0] cmd_wbeats,
  input  logic        wgt_in_vld,
  input  logic        in_vld,
  output logic        in_rdy,
  output logic [15:0] length,
  output logic        is_fft,
  output logic        is_bypass_p2s,
  output logic        butterfly_start,
  output logic [3:0]  stage_idx,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned STG_W  = 4;
  localparam int unsigned WB_W   = 12;
  localparam int unsigned DRN_W  = 8;
  localparam int unsigned MIN_W  = LEN_W + 1;
  // Each input beat carries 2*BU_PARALLELISM points.
  localparam int unsigned BEAT_SHIFT = $clog2(2 * BU_PARALLELISM);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_next;

  logic [WB_W-1:0]    wbeats_q;
  logic [STG_W-1:0]   num_stages_q;
  logic [STG_W-1:0]   stage_next;
  logic [STG_W-1:0]   num_stages_next;

  logic [WB_W-1:0]    wgt_cnt;
  logic [LEN_W-1:0]   beat_cnt;
  logic [DRN_W-1:0]   drain_cnt;

  logic               cmd_accept_c;
  logic               cmd_bad_c;
  logic               cmd_take_c;
  logic [LEN_W-1:0]   beats_per_stage_c;
  logic               wgt_last_c;
  logic               beat_last_c;
  logic               drain_last_c;
  logic               last_stage_c;

  logic               cmd_rdy_d;
  logic               busy_d;
  logic               in_rdy_d;
  logic               start_d;
  logic               bypass_d;
  logic               done_d;
  logic               err_d;

  // Command validation and per-state terminal conditions.
  always_comb begin
    cmd_accept_c = cmd_vld && cmd_rdy;
    cmd_bad_c    = (cmd_length == '0)
                || ((cmd_length & (cmd_length - LEN_W'(1))) != '0)
                || (MIN_W'(cmd_length) < MIN_W'(2 * BU_PARALLELISM))
                || (cmd_num_stages == '0)
                || (cmd_num_stages > STG_W'(MAX_STAGES));
    cmd_take_c   = cmd_accept_c && !cmd_bad_c;

    beats_per_stage_c = length >> BEAT_SHIFT;
    wgt_last_c   = wgt_in_vld && (wgt_cnt == wbeats_q - WB_W'(1));
    beat_last_c  = in_vld && in_rdy && (beat_cnt == beats_per_stage_c - LEN_W'(1));
    drain_last_c = (drain_cnt == DRN_W'(DRAIN_CYCLES - 1));
    last_stage_c = (stage_idx == num_stages_q - STG_W'(1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next state, next stage index and next stage count.
  always_comb begin
    state_next      = state_q;
    stage_next      = stage_idx;
    num_stages_next = num_stages_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_take_c) begin
          state_next      = (cmd_wbeats == '0) ? START : LOAD_W;
          stage_next      = '0;
          num_stages_next = cmd_num_stages;
        end
      end
      LOAD_W: begin
        if (wgt_last_c) begin
          state_next = START;
        end
      end
      START: begin
        state_next = RUN;
      end
      RUN: begin
        if (beat_last_c) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_last_c) begin
          if (last_stage_c) begin
            state_next = IDLE;
          end else begin
            state_next = (wbeats_q == '0) ? START : LOAD_W;
            stage_next = stage_idx + STG_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode. Outputs are computed from the next state so the registered
  // copies line up with the state they describe.
  always_comb begin
    cmd_rdy_d = (state_next == IDLE);
    busy_d    = (state_next != IDLE);
    in_rdy_d  = (state_next == RUN);
    start_d   = (state_next == START);
    bypass_d  = busy_d && (stage_next != (num_stages_next - STG_W'(1)));
    done_d    = (state_q == DRAIN) && drain_last_c && last_stage_c;
    err_d     = cmd_accept_c && cmd_bad_c;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rdy         <= 1'b1;
      busy            <= 1'b0;
      in_rdy          <= 1'b0;
      butterfly_start <= 1'b0;
      is_bypass_p2s   <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      cmd_rdy         <= cmd_rdy_d;
      busy            <= busy_d;
      in_rdy          <= in_rdy_d;
      butterfly_start <= start_d;
      is_bypass_p2s   <= bypass_d;
      done            <= done_d;
      err             <= err_d;
    end
  end

  // Latched command fields and stage index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      length       <= '0;
      is_fft       <= 1'b0;
      wbeats_q     <= '0;
      num_stages_q <= '0;
      stage_idx    <= '0;
    end else begin
      if (cmd_take_c) begin
        length   <= cmd_length;
        is_fft   <= cmd_is_fft;
        wbeats_q <= cmd_wbeats;
      end
      num_stages_q <= num_stages_next;
      stage_idx    <= stage_next;
    end
  end

  // Per-state counters; each is held at zero outside its own state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wgt_cnt   <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (state_q != LOAD_W || wgt_last_c) begin
        wgt_cnt <= '0;
      end else if (wgt_in_vld) begin
        wgt_cnt <= wgt_cnt + WB_W'(1);
      end

      if (state_q != RUN || beat_last_c) begin
        beat_cnt <= '0;
      end else if (in_vld && in_rdy) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end

      if (state_q != DRAIN || drain_last_c) begin
        drain_cnt <= '0;
      end else begin
        drain_cnt <= drain_cnt + DRN_W'(1);
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  // Busy-cycle counter: cleared on a command handshake, saturating, and held
  // once the command completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if (cmd_accept_c) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != '1)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_butterfly_stage_scheduler.sv
// Directed self-checking bench for butterfly_stage_scheduler (default params:
// BU_PARALLELISM=4, DRAIN_CYCLES=16, MAX_STAGES=12).
module tb_butterfly_stage_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [15:0] cmd_length = '0;
  logic        cmd_is_fft = 1'b0;
  logic [3:0]  cmd_num_stages = '0;
  logic [11:0] cmd_wbeats = '0;
  logic        wgt_in_vld = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [15:0] length;
  logic        is_fft;
  logic        is_bypass_p2s;
  logic        butterfly_start;
  logic [3:0]  stage_idx;
  logic        busy;
  logic        done;
  logic        err;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  butterfly_stage_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_vld         (cmd_vld),
    .cmd_rdy         (cmd_rdy),
    .cmd_length      (cmd_length),
    .cmd_is_fft      (cmd_is_fft),
    .cmd_num_stages  (cmd_num_stages),
    .cmd_wbeats      (cmd_wbeats),
    .wgt_in_vld      (wgt_in_vld),
    .in_vld          (in_vld),
    .in_rdy          (in_rdy),
    .length          (length),
    .is_fft          (is_fft),
    .is_bypass_p2s   (is_bypass_p2s),
    .butterfly_start (butterfly_start),
    .stage_idx       (stage_idx),
    .busy            (busy),
    .done            (done),
    .err             (err)
`ifdef SCHED_PERF_CNT_EN
    ,
    .perf_cycles     (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // in_vld pattern: 0 = low, 1 = always high, 2 = toggle every cycle.
  int vld_mode = 0;
  always begin
    @(posedge clk);
    #1;
    case (vld_mode)
      0:       in_vld = 1'b0;
      1:       in_vld = 1'b1;
      default: in_vld = ~in_vld;
    endcase
  end

  // Cumulative event monitor, sampled on the falling edge.
  int   start_cnt = 0;
  int   done_cnt  = 0;
  int   err_cnt   = 0;
  int   busy_cyc  = 0;
  int   quiet_cyc = 0;
  int   rdy_cyc   = 0;
  int   beats[16];
  logic byp_at[64];
  initial for (int i = 0; i < 16; i++) beats[i] = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (butterfly_start) begin
        if (start_cnt < 64) byp_at[start_cnt] = is_bypass_p2s;
        start_cnt++;
      end
      if (in_vld && in_rdy) beats[stage_idx]++;
      if (in_rdy) rdy_cyc++;
      if (busy) busy_cyc++;
      if (busy && !in_rdy && !butterfly_start) quiet_cyc++;
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  int s_start, s_done, s_err, s_busy, s_quiet, s_rdy;
  int s_beats[16];

  task automatic snap();
    s_start = start_cnt;
    s_done  = done_cnt;
    s_err   = err_cnt;
    s_busy  = busy_cyc;
    s_quiet = quiet_cyc;
    s_rdy   = rdy_cyc;
    for (int i = 0; i < 16; i++) s_beats[i] = beats[i];
  endtask

  // Present a command for one cycle; returns just after the handshake edge.
  task automatic send_cmd(input logic [15:0] len, input logic fft,
                          input logic [3:0] stg, input logic [11:0] wb);
    @(posedge clk);
    #1;
    cmd_vld        = 1'b1;
    cmd_length     = len;
    cmd_is_fft     = fft;
    cmd_num_stages = stg;
    cmd_wbeats     = wb;
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  logic [15:0] bad_len [6];
  logic [3:0]  bad_stg [6];

  initial begin
    wgt_in_vld = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_start", 32'(butterfly_start), 32'd0);
    check("rst_stage", 32'(stage_idx), 32'd0);
    check("rst_bypass", 32'(is_bypass_p2s), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_length", 32'(length), 32'd0);
    rst_n = 1'b1;

    // length=64, 3 stages, 2 weight beats, back-to-back data.
    vld_mode = 1;
    snap();
    send_cmd(16'd64, 1'b1, 4'd3, 12'd2);
    @(negedge clk);
    check("a_ld0_start", 32'(butterfly_start), 32'd0);
    check("a_ld0_busy", 32'({busy, cmd_rdy}), 32'b10);
    check("a_latched", 32'({is_fft, length}), 32'h1_0040);
    @(negedge clk);
    check("a_ld1_start", 32'(butterfly_start), 32'd0);
    @(negedge clk);
    check("a_lat_start", 32'(butterfly_start), 32'd1);
    check("a_lat_stage", 32'(stage_idx), 32'd0);
    send_cmd(16'd128, 1'b0, 4'd1, 12'd0);
    check("a_busy_ignore", 32'(length), 32'd64);
    wait_done(400, "a");
    check("a_starts", 32'(start_cnt - s_start), 32'd3);
    check("a_beats0", 32'(beats[0] - s_beats[0]), 32'd8);
    check("a_beats1", 32'(beats[1] - s_beats[1]), 32'd8);
    check("a_beats2", 32'(beats[2] - s_beats[2]), 32'd8);
    check("a_bypass", 32'({byp_at[s_start], byp_at[s_start+1], byp_at[s_start+2]}), 32'b110);
    check("a_done_cnt", 32'(done_cnt - s_done), 32'd1);
    check("a_err_cnt", 32'(err_cnt - s_err), 32'd0);
    check("a_busy_cyc", 32'(busy_cyc - s_busy), 32'd81);
    check("a_quiet_cyc", 32'(quiet_cyc - s_quiet), 32'd54);
    check("a_rdy_cyc", 32'(rdy_cyc - s_rdy), 32'd24);
    check("a_idle_after", 32'({busy, cmd_rdy, is_bypass_p2s}), 32'b010);
`ifdef SCHED_PERF_CNT_EN
    check("a_perf", perf_cycles, 32'd81);
`endif

    // Rejected commands.
    bad_len = '{16'd48, 16'd0, 16'd4, 16'd64, 16'd64, 16'd65535};
    bad_stg = '{4'd3, 4'd1, 4'd1, 4'd0, 4'd13, 4'd2};
    snap();
    for (int i = 0; i < 6; i++) begin
      send_cmd(bad_len[i], 1'b0, bad_stg[i], 12'd1);
      @(negedge clk);
      check($sformatf("rej%0d_err", i), 32'(err), 32'd1);
      check($sformatf("rej%0d_busy", i), 32'({busy, cmd_rdy}), 32'b01);
      @(negedge clk);
      check($sformatf("rej%0d_err_clr", i), 32'(err), 32'd0);
    end
    check("rej_starts", 32'(start_cnt - s_start), 32'd0);
    check("rej_err_cnt", 32'(err_cnt - s_err), 32'd6);

    // wbeats=0: start one cycle after accept; minimum length 8 (1 beat).
    snap();
    send_cmd(16'd8, 1'b0, 4'd1, 12'd0);
    @(negedge clk);
    check("z_start", 32'({butterfly_start, in_rdy}), 32'b10);
    check("z_bypass_last", 32'(is_bypass_p2s), 32'd0);
    @(negedge clk);
    check("z_run", 32'({butterfly_start, in_rdy}), 32'b01);
    @(negedge clk);
    check("z_drain", 32'({busy, in_rdy}), 32'b10);
    wait_done(100, "z");
    check("z_busy_cyc", 32'(busy_cyc - s_busy), 32'd18);
    check("z_beats", 32'(beats[0] - s_beats[0]), 32'd1);

    // Toggling in_vld: only handshakes count; drain is exactly 16 cycles.
    vld_mode = 2;
    snap();
    send_cmd(16'd32, 1'b1, 4'd1, 12'd0);
    wait_done(200, "t");
    check("t_beats", 32'(beats[0] - s_beats[0]), 32'd4);
    check("t_drain", 32'(quiet_cyc - s_quiet), 32'd16);
    check("t_rdy_ge7", 32'((rdy_cyc - s_rdy) >= 7), 32'd1);

    // MAX_STAGES boundary: 12 stages accepted and run.
    vld_mode = 1;
    snap();
    send_cmd(16'd8, 1'b0, 4'd12, 12'd0);
    wait_done(600, "m");
    check("m_starts", 32'(start_cnt - s_start), 32'd12);
    check("m_byp_11_12", 32'({byp_at[s_start+10], byp_at[s_start+11]}), 32'b10);
    check("m_err", 32'(err_cnt - s_err), 32'd0);

    // Reset during stage 1 RUN, then a fresh command.
    snap();
    send_cmd(16'd64, 1'b0, 4'd3, 12'd2);
    begin
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
        @(negedge clk);
        if (stage_idx == 4'd1 && in_rdy) hit = 1'b1;
      end
      check("r_reach_s1_run", 32'(hit), 32'd1);
    end
    rst_n = 1'b0;
    #2;
    check("r_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("r_outs", 32'({busy, in_rdy, butterfly_start, is_bypass_p2s, done, err}), 32'd0);
    check("r_stage_len", 32'({stage_idx, length, is_fft}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("r_no_done", 32'(done_cnt - s_done), 32'd0);
    check("r_no_err", 32'(err_cnt - s_err), 32'd0);
    snap();
    send_cmd(16'd16, 1'b1, 4'd2, 12'd1);
    @(negedge clk);
    check("r2_latched", 32'({is_fft, length}), 32'h1_0010);
    wait_done(200, "r2");
    check("r2_starts", 32'(start_cnt - s_start), 32'd2);
    check("r2_beats0", 32'(beats[0] - s_beats[0]), 32'd2);
    check("r2_beats1", 32'(beats[1] - s_beats[1]), 32'd2);
    check("r2_bypass", 32'({byp_at[s_start], byp_at[s_start+1]}), 32'b10);
    check("r2_busy_cyc", 32'(busy_cyc - s_busy), 32'd40);
    check("r2_done_cnt", 32'(done_cnt - s_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
